// File: rtl/fht_frame_ctrl.sv
// Frame sequencer between an ADC sample stream and fht_top: bit-reversed bank load, start, drain.
// Optional dropped-sample monitor (oOVF, oDROP_CNT) is built when FHT_FRAME_CTRL_OVF_EN is defined.
module fht_frame_ctrl #(
  parameter int A_BIT  = 8,
  parameter int D_BIT  = 16,
  parameter int RD_LAT = 2
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic [D_BIT-2:0]   iADC_DATA,
  input  logic               iADC_VALID,
  output logic [D_BIT-2:0]   oFHT_DATA,
  output logic [A_BIT-1:0]   oFHT_ADDR_WR,
  output logic [3:0]         oFHT_WE,
  output logic               oFHT_START,
  input  logic               iFHT_RDY,
  output logic [A_BIT-1:0]   oFHT_ADDR_RD,
  input  logic [D_BIT-1:0]   iFHT_DATA_0,
  input  logic [D_BIT-1:0]   iFHT_DATA_1,
  input  logic [D_BIT-1:0]   iFHT_DATA_2,
  input  logic [D_BIT-1:0]   iFHT_DATA_3,
  output logic [D_BIT-1:0]   oOUT_DATA,
  output logic               oOUT_VALID,
  input  logic               iOUT_READY,
  output logic               oOUT_LAST,
  output logic               oBUSY,
  output logic               oOVF,
  output logic [15:0]        oDROP_CNT
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_START = 3'd1,
    S_GAP   = 3'd2,
    S_WAIT  = 3'd3,
    S_FETCH = 3'd4,
    S_EMIT  = 3'd5
  } state_t;

  localparam logic [A_BIT+1:0] N_LAST = '1;
  localparam logic [A_BIT+1:0] N_ONE  = {{(A_BIT+1){1'b0}}, 1'b1};
  localparam logic [A_BIT-1:0] A_LAST = '1;
  localparam logic [A_BIT-1:0] A_ONE  = {{(A_BIT-1){1'b0}}, 1'b1};
  localparam logic [1:0]       LAT_C  = 2'(RD_LAT);

  state_t                     state_q, state_d;
  logic [A_BIT+1:0]           n_q, n_d;
  logic [A_BIT-1:0]           a_q, a_d;
  logic [1:0]                 lat_q, lat_d;
  logic [1:0]                 word_q, word_d;
  // Banks 1..3 only; bank 0 goes straight into the output register on capture.
  logic [2:0][D_BIT-1:0]      hold_q, hold_d;
  logic [D_BIT-2:0]           wr_data_q, wr_data_d;
  logic [A_BIT-1:0]           wr_addr_q, wr_addr_d;
  logic [3:0]                 we_q, we_d;
  logic                       start_q, start_d;
  logic                       busy_q, busy_d;
  logic [D_BIT-1:0]           out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    a_d         = a_q;
    lat_d       = lat_q;
    word_d      = word_q;
    hold_d      = hold_q;
    wr_data_d   = wr_data_q;
    wr_addr_d   = wr_addr_q;
    we_d        = 4'b0000;
    start_d     = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_LOAD: begin
        if (iADC_VALID) begin
          wr_data_d = iADC_DATA;
          wr_addr_d = n_q[A_BIT-1:0];
          // Bank index is the two top count bits swapped (bit-reversed order).
          we_d      = 4'b0001 << {n_q[A_BIT], n_q[A_BIT+1]};
          n_d       = n_q + N_ONE;
          if (n_q == N_LAST) begin
            state_d = S_START;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          n_d = n_q;
        end
      end
      S_START: begin
        start_d = 1'b1;
        state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (iFHT_RDY) begin
          state_d = S_FETCH;
          a_d     = '0;
          lat_d   = 2'd0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FETCH: begin
        if (lat_q == LAT_C) begin
          hold_d      = {iFHT_DATA_3, iFHT_DATA_2, iFHT_DATA_1};
          out_data_d  = iFHT_DATA_0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          word_d      = 2'd0;
          state_d     = S_EMIT;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_EMIT: begin
        if (out_valid_q && iOUT_READY) begin
          if (word_q == 2'd3) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            lat_d       = 2'd0;
            a_d         = a_q + A_ONE;
            if (a_q == A_LAST) begin
              state_d = S_LOAD;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            word_d     = word_q + 2'd1;
            out_data_d = hold_q[word_q];
            out_last_d = (a_q == A_LAST) && (word_q == 2'd2);
          end
        end else begin
          word_d = word_q;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
    busy_d = (state_d != S_LOAD);
  end

  // State and output registers.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q     <= S_LOAD;
      n_q         <= '0;
      a_q         <= '0;
      lat_q       <= 2'd0;
      word_q      <= 2'd0;
      hold_q      <= '0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      we_q        <= 4'b0000;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      a_q         <= a_d;
      lat_q       <= lat_d;
      word_q      <= word_d;
      hold_q      <= hold_d;
      wr_data_q   <= wr_data_d;
      wr_addr_q   <= wr_addr_d;
      we_q        <= we_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign oFHT_DATA    = wr_data_q;
  assign oFHT_ADDR_WR = wr_addr_q;
  assign oFHT_WE      = we_q;
  assign oFHT_START   = start_q;
  assign oFHT_ADDR_RD = a_q;
  assign oOUT_DATA    = out_data_q;
  assign oOUT_VALID   = out_valid_q;
  assign oOUT_LAST    = out_last_q;
  assign oBUSY        = busy_q;

`ifdef FHT_FRAME_CTRL_OVF_EN
  logic        drop_s;
  logic        ovf_q;
  logic [15:0] drop_cnt_q;

  assign drop_s = iADC_VALID && (state_q != S_LOAD);

  // Sticky overflow flag and saturating dropped-sample counter.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= 16'h0000;
    end else begin
      ovf_q <= ovf_q | drop_s;
      if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'h0001;
      end else begin
        drop_cnt_q <= drop_cnt_q;
      end
    end
  end

  assign oOVF      = ovf_q;
  assign oDROP_CNT = drop_cnt_q;
`else
  assign oOVF      = 1'b0;
  assign oDROP_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_fht_frame_ctrl.sv
// Directed bench for fht_frame_ctrl: load, start, core handshake, drain, mid-frame reset, drop monitor.
module tb_fht_frame_ctrl;

  localparam int A_BIT  = 8;
  localparam int D_BIT  = 16;
  localparam int RD_LAT = 2;
  localparam int N      = 4 * (2 ** A_BIT);

  logic               clk;
  logic               rst_n;
  logic [D_BIT-2:0]   adc_data;
  logic               adc_valid;
  logic [D_BIT-2:0]   fht_data;
  logic [A_BIT-1:0]   fht_addr_wr;
  logic [3:0]         fht_we;
  logic               fht_start;
  logic               fht_rdy;
  logic [A_BIT-1:0]   fht_addr_rd;
  logic [D_BIT-1:0]   fht_d0, fht_d1, fht_d2, fht_d3;
  logic [D_BIT-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;
  logic               ovf;
  logic [15:0]        drop_cnt;

  int checks = 0;
  int errors = 0;

  fht_frame_ctrl #(.A_BIT(A_BIT), .D_BIT(D_BIT), .RD_LAT(RD_LAT)) dut (
    .iCLK(clk), .iRESET(rst_n),
    .iADC_DATA(adc_data), .iADC_VALID(adc_valid),
    .oFHT_DATA(fht_data), .oFHT_ADDR_WR(fht_addr_wr), .oFHT_WE(fht_we),
    .oFHT_START(fht_start), .iFHT_RDY(fht_rdy), .oFHT_ADDR_RD(fht_addr_rd),
    .iFHT_DATA_0(fht_d0), .iFHT_DATA_1(fht_d1), .iFHT_DATA_2(fht_d2), .iFHT_DATA_3(fht_d3),
    .oOUT_DATA(out_data), .oOUT_VALID(out_valid), .iOUT_READY(out_ready),
    .oOUT_LAST(out_last), .oBUSY(busy), .oOVF(ovf), .oDROP_CNT(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core read model: data follows the read address after RD_LAT clocks.
  logic [A_BIT-1:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    rd_p1 <= fht_addr_rd;
    rd_p2 <= rd_p1;
  end
  assign fht_d0 = 16'd0    + 16'(rd_p2);
  assign fht_d1 = 16'd1000 + 16'(rd_p2);
  assign fht_d2 = 16'd2000 + 16'(rd_p2);
  assign fht_d3 = 16'd3000 + 16'(rd_p2);

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk_val({tag, "_we"},     32'(fht_we),      32'd0);
    chk_val({tag, "_start"},  32'(fht_start),   32'd0);
    chk_val({tag, "_valid"},  32'(out_valid),   32'd0);
    chk_val({tag, "_last"},   32'(out_last),    32'd0);
    chk_val({tag, "_busy"},   32'(busy),        32'd0);
    chk_val({tag, "_addrwr"}, 32'(fht_addr_wr), 32'd0);
    chk_val({tag, "_wdata"},  32'(fht_data),    32'd0);
    chk_val({tag, "_odata"},  32'(out_data),    32'd0);
    chk_val({tag, "_addrrd"}, 32'(fht_addr_rd), 32'd0);
    chk_val({tag, "_ovf"},    32'(ovf),         32'd0);
    chk_val({tag, "_drop"},   32'(drop_cnt),    32'd0);
  endtask

  // Expected write for sample m: bank = {m[8], m[9]}, address = m[7:0].
  task automatic chk_wr(input int m);
    logic [9:0] mv;
    logic [3:0] exp_we;
    mv = 10'(m);
    case ({mv[8], mv[9]})
      2'd0:    exp_we = 4'b0001;
      2'd1:    exp_we = 4'b0010;
      2'd2:    exp_we = 4'b0100;
      default: exp_we = 4'b1000;
    endcase
    chk_val("wr_we",   32'(fht_we),      32'(exp_we));
    chk_val("wr_addr", 32'(fht_addr_wr), 32'(mv[7:0]));
    chk_val("wr_data", 32'(fht_data),    32'(m));
    chk_val("wr_busy", 32'(busy),        32'(m == N - 1));
  endtask

  task automatic load_frame();
    for (int n = 0; n < N; n++) begin
      @(negedge clk);
      if (n > 0) chk_wr(n - 1);
      adc_valid = 1'b1;
      adc_data  = 15'(n);
    end
    @(negedge clk);
    adc_valid = 1'b0;
    chk_wr(N - 1);
    chk_val("start_early", 32'(fht_start), 32'd0);
    @(negedge clk);
    chk_val("start_pulse", 32'(fht_start), 32'd1);
    chk_val("we_after",    32'(fht_we),    32'd0);
    fht_rdy = 1'b0;
  endtask

  task automatic drain(input bit rnd, input int stop_k, input bit chk_time);
    int k = 0;
    int cyc = 0;
    int first = -1;
    logic [D_BIT-1:0] prev_data = '0;
    bit prev_stall = 1'b0;
    while (k < stop_k && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) chk_val("hold_stable", 32'(out_data), 32'(prev_data));
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (out_ready) begin
          chk_val("word", 32'(out_data), 32'(1000 * (k % 4) + k / 4));
          chk_val("last", 32'(out_last), 32'(k == N - 1));
          if (k == N - 1 && chk_time) chk_val("drain_cycles", 32'(cyc - first), 32'd1788);
          k++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    chk_val("drain_count", 32'(k), 32'(stop_k));
  endtask

  initial begin
    logic [31:0] exp_ovf;
    logic [31:0] exp_cnt;
    rst_n     = 1'b0;
    adc_data  = '0;
    adc_valid = 1'b0;
    fht_rdy   = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("rst_rel");

    // Frame 1: ramp load, drops while waiting on the core, full-rate drain.
    load_frame();
    @(negedge clk);
    chk_val("start_one", 32'(fht_start), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i > 0) chk_val("drop_no_we", 32'(fht_we), 32'd0);
      adc_valid = 1'b1;
      adc_data  = 15'(100 + i);
    end
    @(negedge clk);
    adc_valid = 1'b0;
    chk_val("drop_no_we", 32'(fht_we), 32'd0);
`ifdef FHT_FRAME_CTRL_OVF_EN
    exp_ovf = 32'd1;
    exp_cnt = 32'd10;
`else
    exp_ovf = 32'd0;
    exp_cnt = 32'd0;
`endif
    chk_val("ovf",        32'(ovf),       exp_ovf);
    chk_val("drop_cnt",   32'(drop_cnt),  exp_cnt);
    chk_val("wait_valid", 32'(out_valid), 32'd0);
    chk_val("wait_busy",  32'(busy),      32'd1);
    repeat (87) @(negedge clk);
    fht_rdy = 1'b1;
    drain(1'b0, N, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    chk_val("end_busy",  32'(busy),      32'd0);
    chk_val("end_valid", 32'(out_valid), 32'd0);
    chk_val("end_last",  32'(out_last),  32'd0);

    // Frame 2: random sink backpressure.
    load_frame();
    repeat (100) @(negedge clk);
    fht_rdy = 1'b1;
    drain(1'b1, N, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    chk_val("f2_busy", 32'(busy), 32'd0);

    // Frame 3: reset during EMIT at a=37, then restart at bank0 addr0.
    load_frame();
    repeat (20) @(negedge clk);
    fht_rdy = 1'b1;
    drain(1'b0, 150, 1'b0);
    @(negedge clk);
    chk_val("mid_addr_rd", 32'(fht_addr_rd), 32'd37);
    chk_val("mid_valid",   32'(out_valid),   32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    adc_valid = 1'b1;
    adc_data  = 15'd555;
    @(negedge clk);
    adc_valid = 1'b0;
    chk_val("re_we",   32'(fht_we),      32'd1);
    chk_val("re_addr", 32'(fht_addr_wr), 32'd0);
    chk_val("re_data", 32'(fht_data),    32'd555);
    chk_val("re_busy", 32'(busy),        32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
